// File: rtl/camac_cycle_sequencer_if.sv
// ISA-to-CAMAC bus bundle for camac_cycle_sequencer.
// The sequencer is an ISA I/O target and a CAMAC dataway master; it takes
// the slave modport, and the surrounding environment takes the master modport.
interface camac_cycle_sequencer_if;
  // ISA side
  logic        isa_ior;
  logic        isa_iow;
  logic        isa_aen;
  logic [9:0]  isa_addr;
  logic [7:0]  isa_data_in;
  logic [7:0]  isa_data_out;
  logic        isa_data_oe;
  logic        isa_chrdy;
  // CAMAC side
  logic [11:0] cb_addr;
  logic [15:0] cb_data_in;
  logic [15:0] cb_data_out;
  logic        cb_data_oe;
  logic        cb_rd;
  logic        cb_wr;
  logic        cb_prr;
  logic        cb_zk4;
  // Status
  logic        timeout_err;

  modport slave (
    input  isa_ior, isa_iow, isa_aen, isa_addr, isa_data_in,
    input  cb_data_in, cb_prr, cb_zk4,
    output isa_data_out, isa_data_oe, isa_chrdy,
    output cb_addr, cb_data_out, cb_data_oe, cb_rd, cb_wr,
    output timeout_err
  );

  modport master (
    output isa_ior, isa_iow, isa_aen, isa_addr, isa_data_in,
    output cb_data_in, cb_prr, cb_zk4,
    input  isa_data_out, isa_data_oe, isa_chrdy,
    input  cb_addr, cb_data_out, cb_data_oe, cb_rd, cb_wr,
    input  timeout_err
  );
endinterface

// File: rtl/camac_cycle_sequencer.sv
// camac_cycle_sequencer: maps a 64-byte ISA I/O window onto 32 CAMAC
// 16-bit words. Low-byte writes are buffered, high-byte writes launch the
// CAMAC write; low-byte reads launch the CAMAC read, high-byte reads return
// the upper half of the last word read. ISA wait states are inserted via
// isa_chrdy while a CAMAC cycle is in flight.
// Optional feature: define CAMAC_TIMEOUT_EN to abort cycles that see no
// bus-free / acknowledge within TIMEOUT_CYCLES clocks (sets timeout_err and
// returns all-ones read data). Without it the sequencer waits forever.
module camac_cycle_sequencer #(
  parameter logic [9:0]  BASE_ADDR      = 10'h100,
  parameter logic [11:0] CB_BASE        = 12'h000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic                  isa_clk,
  input  logic                  isa_reset,
  camac_cycle_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    STROBE   = 3'd2,
    WAIT_ACK = 3'd3,
    HOLD     = 3'd4
  } stateT;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
    $error("camac_cycle_sequencer: TIMEOUT_CYCLES must be within 2..255");
  end

  stateT       r_state;
  logic        r_iorQ;
  logic        r_iowQ;
  logic        r_isRead;
  logic [7:0]  r_holdLo;
  logic [15:0] r_rdLatch;
  logic [7:0]  r_dataOut;
  logic        r_dataOe;
  logic        r_chrdy;
  logic        r_cbRd;
  logic        r_cbWr;
  logic        r_cbDataOe;
  logic [11:0] r_cbAddr;
  logic [15:0] r_cbDataOut;

  logic        w_iorFall;
  logic        w_iowFall;
  logic        w_inWindow;
  logic        w_bothLow;
  logic        w_rdStart;
  logic        w_wrStart;
  logic        w_hiByte;
  logic        w_camacStart;
  logic [11:0] w_cbAddrNext;
  logic        w_timeout;

  // Decode a qualified ISA access from the strobe falling edges
  assign w_iorFall    = r_iorQ & ~bus.isa_ior;
  assign w_iowFall    = r_iowQ & ~bus.isa_iow;
  assign w_bothLow    = ~bus.isa_ior & ~bus.isa_iow;
  assign w_inWindow   = ~bus.isa_aen & (bus.isa_addr[9:6] == BASE_ADDR[9:6]);
  assign w_rdStart    = w_iorFall & w_inWindow & ~w_bothLow;
  assign w_wrStart    = w_iowFall & w_inWindow & ~w_bothLow;
  assign w_hiByte     = bus.isa_addr[0];
  assign w_camacStart = (w_wrStart & w_hiByte) | (w_rdStart & ~w_hiByte);
  assign w_cbAddrNext = CB_BASE + {7'd0, bus.isa_addr[5:1]};

`ifdef CAMAC_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_toCnt;
  logic       r_timeoutErr;

  assign w_timeout       = (r_toCnt == TO_LAST);
  assign bus.timeout_err = r_timeoutErr;

  // Count clocks spent waiting for bus-free or acknowledge; flag expiry
  always_ff @(posedge isa_clk) begin
    if (!isa_reset) begin
      r_toCnt      <= 8'd0;
      r_timeoutErr <= 1'b0;
    end else if (r_state == IDLE && w_camacStart) begin
      r_toCnt      <= 8'd0;
      r_timeoutErr <= 1'b0;
    end else if ((r_state == SETUP && !bus.cb_zk4) ||
                 (r_state == WAIT_ACK && !bus.cb_prr)) begin
      if (w_timeout) begin
        r_timeoutErr <= 1'b1;
      end else begin
        r_toCnt <= r_toCnt + 8'd1;
      end
    end
  end
`else
  assign w_timeout       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Access sequencer: edge registers, holding registers and all bus outputs
  always_ff @(posedge isa_clk) begin
    if (!isa_reset) begin
      r_state     <= IDLE;
      r_iorQ      <= 1'b1;
      r_iowQ      <= 1'b1;
      r_isRead    <= 1'b0;
      r_holdLo    <= 8'd0;
      r_rdLatch   <= 16'd0;
      r_dataOut   <= 8'd0;
      r_dataOe    <= 1'b0;
      r_chrdy     <= 1'b1;
      r_cbRd      <= 1'b0;
      r_cbWr      <= 1'b0;
      r_cbDataOe  <= 1'b0;
      r_cbAddr    <= 12'd0;
      r_cbDataOut <= 16'd0;
    end else begin
      r_iorQ <= bus.isa_ior;
      r_iowQ <= bus.isa_iow;
      unique case (r_state)
        IDLE: begin
          if (w_wrStart) begin
            r_isRead <= 1'b0;
            if (w_hiByte) begin
              r_cbAddr    <= w_cbAddrNext;
              r_cbDataOut <= {bus.isa_data_in, r_holdLo};
              r_cbDataOe  <= 1'b1;
              r_chrdy     <= 1'b0;
              r_state     <= SETUP;
            end else begin
              r_holdLo <= bus.isa_data_in;
              r_state  <= HOLD;
            end
          end else if (w_rdStart) begin
            r_isRead <= 1'b1;
            if (w_hiByte) begin
              r_dataOut <= r_rdLatch[15:8];
              r_dataOe  <= 1'b1;
              r_state   <= HOLD;
            end else begin
              r_cbAddr <= w_cbAddrNext;
              r_chrdy  <= 1'b0;
              r_state  <= SETUP;
            end
          end
        end
        SETUP: begin
          if (bus.cb_zk4) begin
            r_cbRd  <= r_isRead;
            r_cbWr  <= ~r_isRead;
            r_state <= STROBE;
          end else if (w_timeout) begin
            r_cbDataOe <= 1'b0;
            r_chrdy    <= 1'b1;
            r_state    <= HOLD;
            if (r_isRead) begin
              r_rdLatch <= 16'hFFFF;
              r_dataOut <= 8'hFF;
              r_dataOe  <= ~bus.isa_ior;
            end
          end
        end
        STROBE: begin
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.cb_prr || w_timeout) begin
            r_cbRd     <= 1'b0;
            r_cbWr     <= 1'b0;
            r_cbDataOe <= 1'b0;
            r_chrdy    <= 1'b1;
            r_state    <= HOLD;
            if (r_isRead) begin
              r_rdLatch <= bus.cb_prr ? bus.cb_data_in : 16'hFFFF;
              r_dataOut <= bus.cb_prr ? bus.cb_data_in[7:0] : 8'hFF;
              r_dataOe  <= ~bus.isa_ior;
            end
          end
        end
        HOLD: begin
          if (bus.isa_ior && bus.isa_iow) begin
            r_dataOe <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_dataOe <= r_isRead & ~bus.isa_ior;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.isa_data_out = r_dataOut;
  assign bus.isa_data_oe  = r_dataOe;
  assign bus.isa_chrdy    = r_chrdy;
  assign bus.cb_addr      = r_cbAddr;
  assign bus.cb_data_out  = r_cbDataOut;
  assign bus.cb_data_oe   = r_cbDataOe;
  assign bus.cb_rd        = r_cbRd;
  assign bus.cb_wr        = r_cbWr;

endmodule

// File: doc/camac_cycle_sequencer.md
CAMAC_CYCLE_SEQUENCER -- requirements
Module: camac_cycle_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 10'h100, the ISA I/O window base; the window spans 64 bytes, 0x100-0x13F by default.
REQ-002 SHALL have parameter CB_BASE, default 12'h000, added to the word index to form cb_addr.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, range 2-255, giving the CAMAC acknowledge timeout in isa_clk cycles.
REQ-004 SHALL have port isa_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port isa_reset, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port isa_ior, input, 1 bit: ISA I/O read strobe, active-low.
REQ-007 SHALL have port isa_iow, input, 1 bit: ISA I/O write strobe, active-low.
REQ-008 SHALL have port isa_aen, input, 1 bit: DMA address enable; 1 means ignore the bus.
REQ-009 SHALL have port isa_addr, input, 10 bits: ISA I/O address.
REQ-010 SHALL have port isa_data_in, input, 8 bits: ISA write data.
REQ-011 SHALL have port isa_data_out, output, 8 bits: ISA read data.
REQ-012 SHALL have port isa_data_oe, output, 1 bit: ISA data driver enable.
REQ-013 SHALL have port isa_chrdy, output, 1 bit: channel ready; 0 inserts ISA wait states.
REQ-014 SHALL have port cb_addr, output, 12 bits: CAMAC word address.
REQ-015 SHALL have port cb_data_in, input, 16 bits: CAMAC read data.
REQ-016 SHALL have port cb_data_out, output, 16 bits: CAMAC write data.
REQ-017 SHALL have port cb_data_oe, output, 1 bit: CAMAC data driver enable.
REQ-018 SHALL have ports cb_rd and cb_wr, outputs, 1 bit each: CAMAC read and write strobes, active-high.
REQ-019 SHALL have port cb_prr, input, 1 bit: CAMAC acknowledge, 1 means the cycle is complete.
REQ-020 SHALL have port cb_zk4, input, 1 bit: CAMAC bus free, 0 means busy.
REQ-021 SHALL have port timeout_err, output, 1 bit: sticky acknowledge-timeout flag.

Function
REQ-022 SHALL register isa_ior and isa_iow once and detect each falling edge; an access starts when the edge cycle has isa_aen=0 and isa_addr[9:6]==BASE_ADDR[9:6].
REQ-023 SHALL ignore any edge with both isa_ior and isa_iow low, isa_aen=1, or an address outside the window: no state change, isa_chrdy stays 1, isa_data_oe stays 0.
REQ-024 SHALL set word index = isa_addr[5:1], cb_addr = CB_BASE + index (modulo 2^12), and byte select = isa_addr[0] (0 low, 1 high).
REQ-025 SHALL treat a low-byte write as latching isa_data_in into the low holding byte, with no CAMAC cycle.
REQ-026 SHALL treat a high-byte write as running a CAMAC write of {isa_data_in, low holding byte}.
REQ-027 SHALL treat a low-byte read as running a CAMAC read, latching 16 bits, and returning bits [7:0].
REQ-028 SHALL treat a high-byte read as returning latched bits [15:8], with no CAMAC cycle.
REQ-029 SHALL implement the FSM IDLE -> SETUP -> STROBE -> WAIT_ACK -> HOLD -> IDLE; accesses with no CAMAC cycle go IDLE -> HOLD.
REQ-030 SHALL, in SETUP: drive cb_addr, and for writes drive cb_data_out with cb_data_oe=1; remain in SETUP while cb_zk4=0; go to STROBE when cb_zk4=1.
REQ-031 SHALL, in STROBE, assert cb_rd or cb_wr for one cycle, then go to WAIT_ACK with the strobe still held.
REQ-032 SHALL, in WAIT_ACK, capture cb_data_in on the first cycle with cb_prr=1 (reads), drop the strobes on the next edge, and go to HOLD.
REQ-033 SHALL drive isa_chrdy=0 from the edge-detect cycle+1 until HOLD is entered, and only for CAMAC accesses.
REQ-034 SHALL, in HOLD, drive isa_data_oe=1 only while isa_ior=0 on a read, and return to IDLE one cycle after both strobes read high.
REQ-035 SHALL complete a CAMAC cycle that has started even if the ISA strobe is released mid-cycle; ISA edges during a non-IDLE state are ignored.
REQ-036 SHALL clear timeout_err when a new CAMAC cycle enters SETUP.

Reset
REQ-037 SHALL, on isa_reset=0 at a clock edge, enter IDLE and set: isa_chrdy=1, isa_data_oe=0, cb_rd=0, cb_wr=0, cb_data_oe=0, cb_addr=0, cb_data_out=0, isa_data_out=0, timeout_err=0, holding registers=0, edge registers=1.
REQ-038 SHALL, when reset occurs mid-cycle, abandon the CAMAC cycle with strobes low on that same edge.

Configuration
REQ-039 SHALL compile the timeout feature only when macro CAMAC_TIMEOUT_EN is defined.
REQ-040 SHALL, with CAMAC_TIMEOUT_EN defined: count cycles in SETUP+WAIT_ACK; at TIMEOUT_CYCLES set timeout_err=1, return read data 16'hFFFF, and go to HOLD.
REQ-041 SHALL, without CAMAC_TIMEOUT_EN, wait indefinitely in SETUP and WAIT_ACK, with timeout_err tied 0.

Verification
REQ-042 SHALL cover: iow 0x34 @0x104, then 0x12 @0x105 -> no cb_wr after the first write; one cb_wr, cb_addr=0x002, cb_data_out=0x1234; isa_chrdy=0 until cb_prr.
REQ-043 SHALL cover: ior @0x106, cb_data_in=0xBEEF, cb_prr after 5 cycles -> isa_data_out=0xEF; then ior @0x107 -> 0xBE, no cb_rd, isa_chrdy stays 1.
REQ-044 SHALL cover: CAMAC_TIMEOUT_EN defined, ior @0x100, cb_prr never asserted -> isa_chrdy=1 after 64 cycles, timeout_err=1, isa_data_out=0xFF.
REQ-045 SHALL cover: ior @0x100 with isa_aen=1, and ior @0x0F0 -> no cb_rd, isa_chrdy=1, isa_data_oe=0.
REQ-046 SHALL cover: cb_zk4=0 for 10 cycles during a write to 0x105 -> cb_wr held low until cb_zk4=1, then a single pulse.
REQ-047 SHALL cover: isa_reset=0 during WAIT_ACK -> next edge cb_rd=0, isa_chrdy=1, FSM in IDLE; a following read to 0x102 completes normally.
